// File: rtl/zap_frame_seq_if.sv
// Zapper flash sequencer bus: trigger/hit input, frame strobe,
// video-mux enables and shot-result outputs.
interface zap_frame_seq_if;
    logic [15:0] plyr_input;
    logic        frame_start;
    logic        blank_en;
    logic        target_en;
    logic        busy;
    logic        result_valid;
    logic        result_hit;
    logic [7:0]  hit_cnt;
    logic [7:0]  miss_cnt;

    modport master (
        output plyr_input, frame_start,
        input  blank_en, target_en, busy,
        input  result_valid, result_hit,
        input  hit_cnt, miss_cnt
    );

    modport slave (
        input  plyr_input, frame_start,
        output blank_en, target_en, busy,
        output result_valid, result_hit,
        output hit_cnt, miss_cnt
    );
endinterface

// File: rtl/zap_frame_seq.sv
// Duck-Hunt style flash sequencer: black frame, target frames, hit tally.
// Optional ZAP_CHEAT_REJECT_EN: light seen on the black frame forces a miss.
module zap_frame_seq #(
    parameter int TARGET_FRAMES = 2,
    parameter int TIMEOUT_CYC   = 2000000
) (
    input logic            clk,
    input logic            rst,
    zap_frame_seq_if.slave zif
);
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]    FRM_LAST = 4'(TARGET_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE, ARM, BLANK, TARGET, RESULT, HOLD
    } state_t;

    state_t        state;
    logic          shot_q;
    logic          hit_seen;
    logic [3:0]    frm_cnt;
    logic [CW-1:0] cyc;
`ifdef ZAP_CHEAT_REJECT_EN
    logic          reject;
`endif

    logic shot, hit, fs;
    logic shot_rise, tmo, got_hit;
    logic unused_bits;

    assign shot        = zif.plyr_input[0];
    assign hit         = zif.plyr_input[1];
    assign fs          = zif.frame_start;
    assign unused_bits = ^zif.plyr_input[15:2];
    assign shot_rise   = shot & ~shot_q;
    assign tmo         = ~fs & (cyc == CYC_LAST);
`ifdef ZAP_CHEAT_REJECT_EN
    assign got_hit     = (hit_seen | hit) & ~reject;
`else
    assign got_hit     = hit_seen | hit;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            shot_q           <= 1'b0;
            hit_seen         <= 1'b0;
            frm_cnt          <= '0;
            cyc              <= '0;
            zif.blank_en     <= 1'b0;
            zif.target_en    <= 1'b0;
            zif.busy         <= 1'b0;
            zif.result_valid <= 1'b0;
            zif.result_hit   <= 1'b0;
            zif.hit_cnt      <= '0;
            zif.miss_cnt     <= '0;
`ifdef ZAP_CHEAT_REJECT_EN
            reject           <= 1'b0;
`endif
        end else begin
            shot_q           <= shot;
            zif.result_valid <= 1'b0;
            // Watchdog runs only while waiting on the video timing
            if (state == ARM || state == BLANK || state == TARGET)
                cyc <= fs ? '0 : cyc + 1'b1;
            unique case (state)
                IDLE: begin
                    if (shot_rise) begin
                        state    <= ARM;
                        zif.busy <= 1'b1;
                        hit_seen <= 1'b0;
                        frm_cnt  <= '0;
                        cyc      <= '0;
`ifdef ZAP_CHEAT_REJECT_EN
                        reject   <= 1'b0;
`endif
                    end
                end
                ARM: begin
                    if (fs) begin
                        state        <= BLANK;
                        zif.blank_en <= 1'b1;
                    end else if (tmo) begin
                        state <= HOLD;
                    end
                end
                BLANK: begin
`ifdef ZAP_CHEAT_REJECT_EN
                    if (hit) reject <= 1'b1;
`endif
                    if (fs) begin
                        state         <= TARGET;
                        zif.blank_en  <= 1'b0;
                        zif.target_en <= 1'b1;
                        frm_cnt       <= '0;
                    end else if (tmo) begin
                        state        <= HOLD;
                        zif.blank_en <= 1'b0;
                    end
                end
                TARGET: begin
                    if (hit) hit_seen <= 1'b1;
                    if (fs && frm_cnt == FRM_LAST) begin
                        state            <= RESULT;
                        zif.target_en    <= 1'b0;
                        zif.result_valid <= 1'b1;
                        zif.result_hit   <= got_hit;
                        if (got_hit && zif.hit_cnt != 8'hFF)
                            zif.hit_cnt <= zif.hit_cnt + 8'd1;
                        if (!got_hit && zif.miss_cnt != 8'hFF)
                            zif.miss_cnt <= zif.miss_cnt + 8'd1;
                    end else if (fs) begin
                        frm_cnt <= frm_cnt + 4'd1;
                    end else if (tmo) begin
                        state         <= HOLD;
                        zif.target_en <= 1'b0;
                    end
                end
                RESULT: state <= HOLD;
                HOLD: begin
                    // Trigger must be released before the next shot
                    if (!shot) begin
                        state    <= IDLE;
                        zif.busy <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    zif.busy      <= 1'b0;
                    zif.blank_en  <= 1'b0;
                    zif.target_en <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_zap_frame_seq.sv
// Directed bench for zap_frame_seq: vector table plus reset,
// timeout, last-frame hit and counter saturation sequences.
module tb_zap_frame_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    zap_frame_seq_if zif ();

    zap_frame_seq #(
        .TARGET_FRAMES(2),
        .TIMEOUT_CYC  (100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .zif(zif.slave)
    );

`ifdef ZAP_CHEAT_REJECT_EN
    localparam bit CHEAT = 1'b1;
`else
    localparam bit CHEAT = 1'b0;
`endif

    typedef struct packed {
        logic       shot, hit, fs;
        logic       bl, tg, bz, rv, rh;
        logic [7:0] hc, mc;
    } vec_t;

    vec_t vt[$];

    function automatic void add(
        input logic s, h, f, bl, tg, bz, rv, rh,
        input logic [7:0] hc, mc);
        vec_t v;
        v = '{s, h, f, bl, tg, bz, rv, rh, hc, mc};
        vt.push_back(v);
    endfunction

    function automatic logic [20:0] outs();
        return {zif.blank_en, zif.target_en, zif.busy,
                zif.result_valid, zif.result_hit,
                zif.hit_cnt, zif.miss_cnt};
    endfunction

    task automatic chk(input string nm,
                       input logic [20:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic s, h, f);
        zif.plyr_input  = {14'd0, h, s};
        zif.frame_start = f;
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input logic h,
                           output logic rv, output logic rh);
        step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, h, 1);
        rv = zif.result_valid;
        rh = zif.result_hit;
        step(0, 0, 0);
        step(0, 0, 0);
    endtask

    initial begin
        logic       rh1, rv_s, rh_s, rv_seen;
        logic [7:0] hc1, mc1, mc2;
        rh1 = !CHEAT;
        hc1 = CHEAT ? 8'd1 : 8'd2;
        mc1 = CHEAT ? 8'd1 : 8'd0;
        mc2 = mc1 + 8'd1;

        // shot hit fs | blank target busy rv rh hit miss
        add(1,0,0, 0,0,1,0,0, 1'b0, 0);
        add(1,0,1, 1,0,1,0,0, 0, 0);
        add(1,0,0, 1,0,1,0,0, 0, 0);
        add(1,0,1, 0,1,1,0,0, 0, 0);
        add(1,0,0, 0,1,1,0,0, 0, 0);
        add(1,0,1, 0,1,1,0,0, 0, 0);
        add(1,1,0, 0,1,1,0,0, 0, 0);
        add(1,0,1, 0,0,1,1,1, 1, 0);
        add(1,0,0, 0,0,1,0,1, 1, 0);
        add(0,0,0, 0,0,0,0,1, 1, 0);
        add(0,0,1, 0,0,0,0,1, 1, 0);
        // rise together with frame_start: ARM lasts one frame
        add(1,0,1, 0,0,1,0,1, 1, 0);
        add(1,0,0, 0,0,1,0,1, 1, 0);
        add(1,0,1, 1,0,1,0,1, 1, 0);
        add(1,1,1, 0,1,1,0,1, 1, 0);
        add(1,1,0, 0,1,1,0,1, 1, 0);
        add(1,0,1, 0,1,1,0,1, 1, 0);
        add(1,0,1, 0,0,1,1,rh1, hc1, mc1);
        add(1,0,0, 0,0,1,0,rh1, hc1, mc1);
        add(1,0,1, 0,0,1,0,rh1, hc1, mc1);
        add(0,0,0, 0,0,0,0,rh1, hc1, mc1);
        // held trigger, no hit
        add(1,0,0, 0,0,1,0,rh1, hc1, mc1);
        add(1,0,1, 1,0,1,0,rh1, hc1, mc1);
        add(1,0,1, 0,1,1,0,rh1, hc1, mc1);
        add(1,0,1, 0,1,1,0,rh1, hc1, mc1);
        add(1,0,1, 0,0,1,1,0, hc1, mc2);
        add(1,0,0, 0,0,1,0,0, hc1, mc2);
        add(1,0,1, 0,0,1,0,0, hc1, mc2);
        add(1,0,0, 0,0,1,0,0, hc1, mc2);
        add(0,0,0, 0,0,0,0,0, hc1, mc2);
        add(1,0,0, 0,0,1,0,0, hc1, mc2);
        add(1,0,1, 1,0,1,0,0, hc1, mc2);
        add(1,0,1, 0,1,1,0,0, hc1, mc2);

        zif.plyr_input  = '0;
        zif.frame_start = 1'b0;
        rst = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("reset_state", outs(), 21'd0);
        rst = 1'b1;
        step(0, 0, 0);
        chk("idle_after_reset", outs(), 21'd0);

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].shot, vt[i].hit, vt[i].fs);
            chk($sformatf("vec%0d", i), outs(),
                {vt[i].bl, vt[i].tg, vt[i].bz, vt[i].rv,
                 vt[i].rh, vt[i].hc, vt[i].mc});
        end

        // reset while the target box is up
        rst = 1'b0;
        step(1, 1, 0);
        chk("midreset_c1", outs(), 21'd0);
        step(1, 1, 1);
        chk("midreset_c2", outs(), 21'd0);
        rst = 1'b1;
        step(0, 0, 0);
        chk("midreset_release", outs(), 21'd0);

        // no frame_start: watchdog drops to HOLD after 100 cycles
        step(1, 0, 0);
        rv_seen = 1'b0;
        for (int k = 1; k <= 101; k++) begin
            step(0, 0, 0);
            rv_seen |= zif.result_valid;
            if (k == 99)
                chk("tmo_armed_99", outs(), {3'b001, 18'd0});
            if (k == 100)
                chk("tmo_hold_100", outs(), {3'b001, 18'd0});
            if (k == 101)
                chk("tmo_idle_101", outs(), 21'd0);
        end
        chk("tmo_no_result", {20'd0, rv_seen}, 21'd0);
        step(0, 0, 1);
        step(0, 0, 1);
        chk("tmo_no_restart", outs(), 21'd0);

        // hit only on the final frame_start cycle
        run_seq(1'b1, rv_s, rh_s);
        chk("lastframe_hit", {rv_s, rh_s, zif.hit_cnt},
            {2'b11, 8'd1});

        // miss counter saturation
        for (int n = 1; n <= 257; n++) begin
            run_seq(1'b0, rv_s, rh_s);
            if (n == 1)
                chk("miss_first", {rv_s, rh_s, zif.miss_cnt},
                    {2'b10, 8'd1});
            if (n == 254)
                chk("miss_254", {13'd0, zif.miss_cnt},
                    {13'd0, 8'd254});
            if (n == 255)
                chk("miss_255", {13'd0, zif.miss_cnt},
                    {13'd0, 8'hFF});
            if (n == 257)
                chk("miss_sat", outs(), {5'b00000, 8'd1, 8'hFF});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
